// File: rtl/proc_pkg.sv
// Shared encodings for the instruction stage sequencer.
// States, opcode constants, error codes and opcode classes.
package proc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } opclass_t;

  localparam logic [6:0] OP_HALT   = 7'b0000000;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_MEM_TO  = 2'b10;
  localparam logic [1:0] ERR_MISALGN = 2'b11;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts MEMORY-state cycles; expired marks the LIMIT-th one.
// Ports: clk, rst (async), clr (sync), en, expired.
module mem_timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // cnt holds the number of MEMORY cycles already completed,
  // so expired is high during the LIMIT-th cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer with pc and retire count.
// Ports: run/halt_req control, opcode/branch/imm/mem_ready inputs,
// one-hot stage enables, pc, state, halted, err, instr_count.
module stage_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        halt_req,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic [63:0] imm,
  input  logic        mem_ready,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  err,
  output logic [31:0] instr_count
);

  state_t      cur, nxt;
  opclass_t    cls, cls_next;
  logic        cls_wr;
  logic        retire;
  logic [31:0] pc_next;
  logic [31:0] target;
  logic        err_wr;
  logic [1:0]  err_code;
  logic        mem_clr;
  logic        expired;
  logic        unused_imm_hi;

  assign unused_imm_hi = ^imm[63:32];
  assign target        = pc + imm[31:0];
  assign mem_clr       = (cur == ST_EXECUTE) && (nxt == ST_MEMORY);

  mem_timeout_counter #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (mem_clr),
    .en     (cur == ST_MEMORY),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= ST_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt      = cur;
    retire   = 1'b0;
    pc_next  = pc + 32'd4;
    cls_wr   = 1'b0;
    cls_next = cls;
    err_wr   = 1'b0;
    err_code = ERR_NONE;
    case (cur)
      ST_IDLE: if (run) nxt = ST_FETCH;
      ST_FETCH: nxt = ST_DECODE;
      ST_DECODE: begin
        nxt    = ST_EXECUTE;
        cls_wr = 1'b1;
        case (opcode)
          OP_RTYPE,
          OP_ITYPE:  cls_next = CLS_ALU;
          OP_LOAD:   cls_next = CLS_LOAD;
          OP_STORE:  cls_next = CLS_STORE;
          OP_BRANCH: cls_next = CLS_BRANCH;
          OP_HALT: begin
            cls_wr = 1'b0;
            nxt    = ST_HALT;
            err_wr = 1'b1;
          end
          default: begin
            cls_wr   = 1'b0;
            nxt      = ST_HALT;
            err_wr   = 1'b1;
            err_code = ERR_ILLEGAL;
          end
        endcase
      end
      ST_EXECUTE: begin
        case (cls)
          CLS_ALU:   nxt = ST_WRITEBACK;
          CLS_LOAD,
          CLS_STORE: nxt = ST_MEMORY;
          default: begin
            if (branch_taken && misaligned(target)) begin
              nxt      = ST_HALT;
              err_wr   = 1'b1;
              err_code = ERR_MISALGN;
            end else begin
              retire = 1'b1;
              if (branch_taken) pc_next = target;
            end
          end
        endcase
      end
      ST_MEMORY: begin
        if (mem_ready) begin
          if (cls == CLS_LOAD) nxt = ST_WRITEBACK;
          else                 retire = 1'b1;
        end else if (expired) begin
          nxt      = ST_HALT;
          err_wr   = 1'b1;
          err_code = ERR_MEM_TO;
        end
      end
      ST_WRITEBACK: retire = 1'b1;
      ST_HALT: nxt = ST_HALT;
      default: begin
        nxt      = ST_HALT;
        err_wr   = 1'b1;
        err_code = ERR_ILLEGAL;
      end
    endcase
    if (retire) nxt = halt_req ? ST_IDLE : ST_FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr_count <= '0;
      err         <= ERR_NONE;
      cls         <= CLS_ALU;
    end else begin
      if (retire) begin
        pc          <= pc_next;
        instr_count <= instr_count + 32'd1;
      end
      if (err_wr) err <= err_code;
      if (cls_wr) cls <= cls_next;
    end
  end

  always_comb begin
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    execute_en = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    case (cur)
      ST_FETCH:     fetch_en   = 1'b1;
      ST_DECODE:    decode_en  = 1'b1;
      ST_EXECUTE:   execute_en = 1'b1;
      ST_MEMORY:    mem_en     = 1'b1;
      ST_WRITEBACK: wb_en      = 1'b1;
      default: ;
    endcase
  end

  assign state  = cur;
  assign halted = (cur == ST_HALT);

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer.
// Hand-computed pc/count/state/err expectations.
module tb_stage_sequencer;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic        clk;
  logic        rst;
  logic        run;
  logic        halt_req;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic [63:0] imm;
  logic        mem_ready;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        mem_en;
  logic        wb_en;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  err;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  stage_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .halt_req    (halt_req),
    .opcode      (opcode),
    .branch_taken(branch_taken),
    .imm         (imm),
    .mem_ready   (mem_ready),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .execute_en  (execute_en),
    .mem_en      (mem_en),
    .wb_en       (wb_en),
    .pc          (pc),
    .state       (state),
    .halted      (halted),
    .err         (err),
    .instr_count (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] exp_en(input logic [2:0] s);
    case (s)
      3'd1:    return 5'b10000;
      3'd2:    return 5'b01000;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b00010;
      3'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk_st(input string tag, input logic [2:0] s);
    chk({tag, ".state"}, state, s);
    chk({tag, ".en"},
        {fetch_en, decode_en, execute_en, mem_en, wb_en}, exp_en(s));
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; halt_req = 1'b0; opcode = '0;
    branch_taken = 1'b0; imm = '0; mem_ready = 1'b0;
    #3;
    chk_st("rst", 3'd0);
    chk("rst.pc", pc, 32'h0);
    chk("rst.cnt", instr_count, 32'h0);
    chk("rst.err", err, 2'b00);
    chk("rst.halted", halted, 1'b0);
    #9 rst = 1'b0;

    step;
    chk_st("idle_wait", 3'd0);

    run = 1'b1; opcode = OP_R;
    step; chk_st("r.f", 3'd1);
    step; chk_st("r.d", 3'd2);
    step; chk_st("r.e", 3'd3);
    step; chk_st("r.wb", 3'd5);
    chk("r.wb.pc", pc, 32'h0);
    step; chk_st("r.ret", 3'd1);
    chk("r.pc", pc, 32'd4);
    chk("r.cnt", instr_count, 32'd1);

    opcode = OP_I;
    step(4); chk_st("i.ret", 3'd1);
    chk("i.pc", pc, 32'd8);
    chk("i.cnt", instr_count, 32'd2);

    opcode = OP_BR; branch_taken = 1'b1; imm = 64'd16;
    step(2); chk_st("bt.e", 3'd3);
    step; chk_st("bt.ret", 3'd1);
    chk("bt.pc", pc, 32'd24);
    chk("bt.cnt", instr_count, 32'd3);

    branch_taken = 1'b0;
    step(3); chk_st("bn.ret", 3'd1);
    chk("bn.pc", pc, 32'd28);
    chk("bn.cnt", instr_count, 32'd4);

    opcode = OP_LD; mem_ready = 1'b0;
    step(3); chk_st("ld.m1", 3'd4);
    step(2); chk_st("ld.m3", 3'd4);
    mem_ready = 1'b1;
    step; chk_st("ld.wb", 3'd5);
    mem_ready = 1'b0;
    step; chk_st("ld.ret", 3'd1);
    chk("ld.pc", pc, 32'd32);
    chk("ld.cnt", instr_count, 32'd5);

    opcode = OP_ST; mem_ready = 1'b1;
    step(3); chk_st("st.m", 3'd4);
    step; chk_st("st.ret", 3'd1);
    chk("st.pc", pc, 32'd36);
    chk("st.cnt", instr_count, 32'd6);
    mem_ready = 1'b0;

    opcode = OP_R;
    step(2); chk_st("hr.e", 3'd3);
    halt_req = 1'b1;
    step; chk_st("hr.wb", 3'd5);
    step; chk_st("hr.ret", 3'd0);
    chk("hr.pc", pc, 32'd40);
    chk("hr.cnt", instr_count, 32'd7);
    step; chk_st("hr.idle_run", 3'd1);
    halt_req = 1'b0;

    opcode = OP_BR; branch_taken = 1'b1; imm = 64'd18;
    step(3); chk_st("mis", 3'd6);
    chk("mis.halted", halted, 1'b1);
    chk("mis.err", err, 2'b11);
    chk("mis.pc", pc, 32'd40);
    chk("mis.cnt", instr_count, 32'd7);

    halt_req = 1'b1;
    step(2); chk_st("halt.sticky", 3'd6);
    chk("halt.err", err, 2'b11);
    halt_req = 1'b0;

    pulse_rst();
    chk_st("rst.halt", 3'd0);
    chk("rst.halt.err", err, 2'b00);
    chk("rst.halt.pc", pc, 32'h0);
    chk("rst.halt.cnt", instr_count, 32'h0);
    chk("rst.halt.halted", halted, 1'b0);
    #1 rst = 1'b0;

    step; chk_st("wr.f", 3'd1);
    opcode = OP_BR; branch_taken = 1'b1;
    imm = 64'hDEAD_BEEF_FFFF_FFFC;
    step(3);
    chk("wr.br.pc", pc, 32'hFFFF_FFFC);
    chk("wr.br.cnt", instr_count, 32'd1);
    opcode = OP_R; branch_taken = 1'b0;
    step(4);
    chk("wr.r.pc", pc, 32'h0);
    chk("wr.r.cnt", instr_count, 32'd2);

    opcode = OP_ST; mem_ready = 1'b0;
    step(3); chk_st("to.m1", 3'd4);
    step(14); chk_st("to.m15", 3'd4);
    step; chk_st("to.halt", 3'd6);
    chk("to.err", err, 2'b10);
    chk("to.cnt", instr_count, 32'd2);

    pulse_rst();
    #1 rst = 1'b0;
    step; opcode = OP_R;
    step(4);
    chk("rm.pre.pc", pc, 32'd4);
    opcode = OP_LD;
    step(4); chk_st("rm.m2", 3'd4);
    pulse_rst();
    chk_st("rm.rst", 3'd0);
    chk("rm.pc", pc, 32'h0);
    chk("rm.cnt", instr_count, 32'h0);
    #1 rst = 1'b0;
    run = 1'b0;
    step; chk_st("rm.idle", 3'd0);

    run = 1'b1; opcode = 7'b1111111;
    step(3); chk_st("ill", 3'd6);
    chk("ill.err", err, 2'b01);
    chk("ill.halted", halted, 1'b1);

    pulse_rst();
    #1 rst = 1'b0;
    opcode = 7'b0000000;
    step(3); chk_st("hlt", 3'd6);
    chk("hlt.err", err, 2'b00);
    chk("hlt.halted", halted, 1'b1);
    chk("hlt.cnt", instr_count, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
